// File: rtl/uut.sv
// Wishbone slave in front of a 4096x32 SDRAM-like array: ACTIVATE/READ|WRITE/PRECHARGE timing plus periodic refresh.
// Ack arrives TRCD+1+TRP edges after acceptance for writes, TRCD+TCAS+TRP for reads. Requests are only taken in IDLE.
module uut #(
  parameter int TRCD = 2,
  parameter int TCAS = 2,
  parameter int TRP  = 2,
  parameter int TREF = 100,
  parameter int TRFC = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int RW = $clog2(TREF + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVATE,
    S_READ,
    S_WRITE,
    S_PRECHARGE,
    S_ACK,
    S_REFRESH
  } state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend;
  logic          ref_due;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   dat_q;
  logic [11:0]   adr_q;   // {bank[1:0], row[1:0], column[7:0]}
  logic [3:0]    wmask;
  logic [31:0]   mem [4096];
  logic          unused_adr_hi;

  assign unused_adr_hi = ^wbs_adr_i[31:12];
  assign ref_due       = (ref_cnt == RW'(TREF - 1));
  assign wmask         = (sel_q == 4'b0000) ? 4'b1111 : sel_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ref_cnt   <= '0;
      ref_pend  <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      dat_q     <= 32'h0;
      adr_q     <= 12'h0;
    end else begin
      ref_cnt   <= ref_due ? '0 : ref_cnt + 1'b1;
      if (ref_due) ref_pend <= 1'b1;
      wbs_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // A refresh falling due on this very edge already outranks a request.
          if (ref_pend || ref_due) begin
            state    <= S_REFRESH;
            cnt      <= '0;
            ref_pend <= 1'b0;
          end else if (wbs_stb_i && wbs_cyc_i) begin
            state <= S_ACTIVATE;
            cnt   <= '0;
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            dat_q <= wbs_dat_i;
            adr_q <= wbs_adr_i[11:0];
          end
        end
        S_ACTIVATE: begin
          if (cnt == 16'(TRCD - 1)) begin
            cnt   <= '0;
            state <= we_q ? S_WRITE : S_READ;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WRITE: begin
          cnt   <= '0;
          state <= S_PRECHARGE;
        end
        S_READ: begin
          if (cnt == 16'(TCAS - 1)) begin
            cnt   <= '0;
            state <= S_PRECHARGE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_PRECHARGE: begin
          if (cnt == 16'(TRP - 1)) begin
            cnt       <= '0;
            state     <= S_ACK;
            wbs_ack_o <= 1'b1;
            if (!we_q) wbs_dat_o <= mem[adr_q];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        S_REFRESH: begin
          if (cnt == 16'(TRFC - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage has no reset; a reset landing on the WRITE edge suppresses the write.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && state == S_WRITE) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[adr_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_uut.sv
// Scoreboard bench for uut: read data expected from a byte-merging memory model, ack timing from the access sequence.
module tb_uut;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_ack = 0;
  int rst_edge = 0;

  logic [31:0] mdl [int];
  logic [31:0] sb [$];

  uut dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;
  always @(negedge wb_clk_i) if (wbs_ack_o) n_ack++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [3:0]  m;
    logic [31:0] w;
    int          idx;
    idx = int'(adr[11:0]);
    m = (sel == 4'b0000) ? 4'b1111 : sel;
    w = mdl.exists(idx) ? mdl[idx] : 32'h0;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = dat[8*b +: 8];
    mdl[idx] = w;
  endfunction

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    step();
    step();
    rst_edge = cyc;
    wb_rst_i = 1'b0;
  endtask

  // mode 0: strobe for one edge then scramble inputs; 1: hold until ack; 2: keep strobe after ack
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int mode, input int exp_lat, input string tag);
    int          t0;
    bit          got;
    logic [31:0] exp;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    if (we) model_wr(adr, dat, sel);
    else    sb.push_back(mdl[int'(adr[11:0])]);
    t0  = cyc + 1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (mode == 0) begin
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = ~we;
        wbs_adr_i = adr ^ 32'h0000_03ff;
        wbs_dat_i = ~dat;
        wbs_sel_i = ~sel;
      end
      if (wbs_ack_o) got = 1'b1;
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      if (exp_lat > 0) check({tag, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
      if (!we) begin
        exp = sb.pop_front();
        check({tag, "_rdat"}, wbs_dat_o, exp);
      end
    end
    if (mode != 2) begin
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
    end
    step();
    check({tag, "_pulse"}, 32'(wbs_ack_o), 32'd0);
  endtask

  initial begin
    logic [31:0] adrs [5];
    logic [31:0] dats [5];
    int          a0;

    // reset state
    do_reset();
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);

    // basic write/read with exact ack latency and latched inputs
    do_req(1'b1, 32'h024, 32'h12153524, 4'h0, 0, 5, "wr024");
    do_req(1'b0, 32'h024, 32'h0, 4'h0, 0, 6, "rd024");
    do_req(1'b1, 32'h300, 32'h5A5A_0F0F, 4'hF, 0, 5, "wr300");
    check("dat_hold_after_wr", wbs_dat_o, 32'h12153524);

    // back-to-back with strobe held: exactly ten acks
    a0 = n_ack;
    for (int i = 0; i < 5; i++) begin
      adrs[i] = 32'h200 + 32'(i) * 32'h111;
      dats[i] = $urandom;
    end
    for (int i = 0; i < 5; i++) do_req(1'b1, adrs[i], dats[i], 4'h0, 2, 0, "b2b_wr");
    for (int i = 0; i < 5; i++) do_req(1'b0, adrs[i], 32'h0, 4'h0, (i == 4) ? 1 : 2, 0, "b2b_rd");
    check("b2b_ack_count", 32'(n_ack - a0), 32'd10);

    // byte-lane merge, read not masked by sel
    do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 1, 0, "wr100");
    do_req(1'b1, 32'h100, 32'h00AB0000, 4'b0100, 1, 0, "wr100_lane2");
    do_req(1'b0, 32'h100, 32'h0, 4'b0001, 1, 0, "rd100");
    check("merge_value", wbs_dat_o, 32'hFFABFFFF);

    // upper address bits ignored
    do_req(1'b1, 32'h00001024, 32'hCAFEF00D, 4'h0, 1, 0, "wr_alias");
    do_req(1'b0, 32'h024, 32'h0, 4'h0, 1, 0, "rd_alias");

    // refresh due on the edge before the request: ack delayed by TRFC
    do_reset();
    while (cyc < rst_edge + 100) step();
    do_req(1'b1, 32'h040, 32'h0BAD_BEEF, 4'h0, 1, 5 + 4, "wr_refresh");
    do_req(1'b0, 32'h040, 32'h0, 4'h0, 1, 0, "rd_after_ref");
    do_req(1'b0, 32'h100, 32'h0, 4'h0, 1, 0, "rd100_after_ref");

    // reset three cycles into a read
    a0 = n_ack;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 32'h024;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    step();
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    step();
    step();
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    repeat (10) step();
    check("abort_no_ack", 32'(n_ack - a0), 32'd0);
    check("abort_dat_zero", wbs_dat_o, 32'h0);
    do_req(1'b0, 32'h024, 32'h0, 4'h0, 0, 6, "rd_after_abort");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uut.md
UUT -- requirements
Module: uut

Interface
REQ-001 The block SHALL have the parameter TRCD, default 2: number of cycles spent in ACTIVATE.
REQ-002 The block SHALL have the parameter TCAS, default 2: number of cycles spent in READ (CAS latency).
REQ-003 The block SHALL have the parameter TRP, default 2: number of cycles spent in PRECHARGE.
REQ-004 The block SHALL have the parameter TREF, default 100: refresh interval in cycles.
REQ-005 The block SHALL have the parameter TRFC, default 4: number of cycles spent in REFRESH.
REQ-006 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-007 Port wb_clk_i SHALL be an input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 Port wb_rst_i SHALL be an input, 1 bit: the synchronous active-high reset.
REQ-009 Port wbs_stb_i SHALL be an input, 1 bit: Wishbone strobe.
REQ-010 Port wbs_cyc_i SHALL be an input, 1 bit: Wishbone cycle.
REQ-011 Port wbs_we_i SHALL be an input, 1 bit: 1 = write, 0 = read.
REQ-012 Port wbs_sel_i SHALL be an input, 4 bits: byte-lane enables; bit n selects data bits [8n+7:8n].
REQ-013 Port wbs_dat_i SHALL be an input, 32 bits: write data.
REQ-014 Port wbs_adr_i SHALL be an input, 32 bits: word address; only bits [11:0] are used.
REQ-015 Port wbs_ack_o SHALL be an output, 1 bit: transaction-complete pulse.
REQ-016 Port wbs_dat_o SHALL be an output, 32 bits: read data.

Function
REQ-017 The block SHALL contain 4096 x 32-bit word storage indexed by wbs_adr_i[11:0], mapped as bank = [11:10], row = [9:8], column = [7:0]; wbs_adr_i[31:12] SHALL be ignored.
REQ-018 The state machine SHALL have the states IDLE, ACTIVATE, READ, WRITE, PRECHARGE, ACK and REFRESH.
REQ-019 A request SHALL be accepted only in IDLE, on a rising edge where wbs_stb_i=1 and wbs_cyc_i=1; at that edge wbs_adr_i, wbs_we_i, wbs_sel_i and wbs_dat_i SHALL be latched, and later input changes SHALL NOT affect the transaction.
REQ-020 The transaction sequence SHALL be IDLE -> ACTIVATE (TRCD cycles) -> WRITE (1 cycle) or READ (TCAS cycles) -> PRECHARGE (TRP cycles) -> ACK (1 cycle) -> IDLE.
REQ-021 A write SHALL update storage at the WRITE-state edge, only on byte lanes whose sel bit is 1; sel = 4'b0000 SHALL be treated as 4'b1111 (full-word write).
REQ-022 A read SHALL fetch the full 32-bit word; wbs_sel_i SHALL NOT mask read data.
REQ-023 wbs_ack_o SHALL be registered and high for exactly one cycle, while in ACK; it SHALL rise TRCD+1+TRP (=5) edges after the acceptance edge for a write and TRCD+TCAS+TRP (=6) edges after it for a read.
REQ-024 wbs_dat_o SHALL be loaded with the read word on the same edge wbs_ack_o rises, and SHALL hold that value until the next read completes; writes SHALL NOT change wbs_dat_o.
REQ-025 ACK SHALL always return to IDLE; with wbs_stb_i and wbs_cyc_i held high, the next request SHALL be sampled on the first edge in IDLE, so back-to-back requests SHALL each get exactly one ack, with no duplicate acceptance.
REQ-026 A refresh counter SHALL count every cycle and set refresh-pending on reaching TREF-1, then restart from 0.
REQ-027 In IDLE, a pending refresh SHALL take priority over a new request: IDLE -> REFRESH (TRFC cycles) -> IDLE, clearing pending; no ack SHALL be issued and storage SHALL be unchanged.
REQ-028 A refresh that comes due during a transaction SHALL wait until the block returns to IDLE.
REQ-029 A read of a location written earlier SHALL return the merged written bytes; a read of a never-written location SHALL return undefined data.
REQ-030 Deasserting wbs_stb_i or wbs_cyc_i mid-transaction SHALL NOT abort the transaction; it SHALL complete and ack.

Reset
REQ-031 When wb_rst_i=1 at a rising edge: state SHALL go to IDLE, wbs_ack_o=0, wbs_dat_o=32'h0, refresh counter=0, pending=0, and any latched request SHALL be discarded.
REQ-032 Reset asserted mid-operation SHALL abort the transaction with no ack; the storage write SHALL occur only if the WRITE edge was already reached.
REQ-033 Storage contents SHALL NOT be cleared by reset.
REQ-034 Reset SHALL take precedence over all other events in the same cycle.

Verification
REQ-035 Reset, then write adr=0x024, dat=0x12153524, sel=0 -> one ack pulse 5 edges after acceptance; a subsequent read of 0x024 -> ack 6 edges after acceptance with wbs_dat_o=0x12153524.
REQ-036 Stb/cyc held high, 5 writes to distinct addresses, then 5 reads of the same addresses -> exactly 10 ack pulses, and every read returns its written word.
REQ-037 Write 0xFFFFFFFF to 0x100, then write 0x00AB0000 with sel=4'b0100 -> a read of 0x100 returns 0xFFABFFFF.
REQ-038 Idle for 100 cycles, then issue a request at the edge refresh becomes pending -> REFRESH for 4 cycles, and the ack is delayed by exactly 4 cycles.
REQ-039 Assert reset 3 cycles into a read -> no ack, wbs_dat_o=0; a following read completes normally.
REQ-040 Write with wbs_adr_i=0x00001024 -> aliases 0x024; a read of 0x024 returns the written data.
